// File: rtl/fire5_squeeze_mac.sv
// fire5_squeeze_mac
// 1x1 convolution engine for the fire5 squeeze layer. It takes one activation
// per input channel, multiplies it by the NUM weights that the squeeze weight
// ROM returns for the current channel, and accumulates the products into NUM
// lanes. When the last channel has been accepted, it converts each lane to a
// rescaled, ReLU'd and saturated output and presents the pixel over a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   act_in/act_valid     signed activation for the current channel
//   act_ready            engine accepts act_in this cycle
//   rom_addr             channel address to the weight ROM (combinational read)
//   rom_data[0:NUM-1]    signed weights for rom_addr, one per lane
//   out_data[0:NUM-1]    per-lane result of the completed pixel
//   out_valid/out_ready  output handshake
//   busy                 pixel partially accumulated or its result pending
module fire5_squeeze_mac #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 8,
    parameter int NUM   = 32,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] act_in,
    input  logic             act_valid,
    output logic             act_ready,
    output logic [ADDR-1:0]  rom_addr,
    input  logic [WIDTH-1:0] rom_data [0:NUM-1],
    output logic [WIDTH-1:0] out_data [0:NUM-1],
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [0:0]      ST_ACC  = 1'b0;
    localparam logic [0:0]      ST_OUT  = 1'b1;
    localparam logic [ADDR-1:0] LAST_CH = '1;
    localparam int              PROD_W  = 2 * WIDTH;

    // Largest positive output word, widened to accumulator width for compares.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

    logic [0:0]      state_q, state_d;
    logic [ADDR-1:0] cnt_q, cnt_d;
    logic            en_q, en_d;

    logic signed [ACC_W-1:0]  acc_q [0:NUM-1];
    logic signed [ACC_W-1:0]  acc_d [0:NUM-1];
    logic        [WIDTH-1:0]  out_q [0:NUM-1];
    logic        [WIDTH-1:0]  out_d [0:NUM-1];

    logic signed [PROD_W-1:0] act_ext;
    logic signed [PROD_W-1:0] wgt_ext [0:NUM-1];
    logic signed [PROD_W-1:0] prod    [0:NUM-1];
    logic signed [ACC_W-1:0]  sum     [0:NUM-1];

    logic accept;
    logic last_accept;
    logic handshake;

    // Rescale, ReLU and saturate one final lane sum.
    function automatic logic [WIDTH-1:0] convert(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> FRAC;
        if (s < 0) begin
            return '0;
        end else if (s > SAT_MAX) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            return s[WIDTH-1:0];
        end
    endfunction

    assign act_ready = en_q && (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign rom_addr  = cnt_q;
    assign busy      = (cnt_q != '0) || (state_q == ST_OUT);
    assign out_data  = out_q;

    assign accept      = act_valid && act_ready;
    assign last_accept = accept && (cnt_q == LAST_CH);
    assign handshake   = out_valid && out_ready;

    // Operands are sign-extended to the product width so the low 2*WIDTH bits
    // of the multiply are the exact signed product.
    assign act_ext = {{WIDTH{act_in[WIDTH-1]}}, act_in};

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = 1'b1;

        if (accept) begin
            cnt_d = cnt_q + 1'b1;   // wraps to 0 after the last channel
        end

        if (last_accept) begin
            state_d = ST_OUT;
        end else if (handshake) begin
            state_d = ST_ACC;
        end

        for (int i = 0; i < NUM; i++) begin
            wgt_ext[i] = {{WIDTH{rom_data[i][WIDTH-1]}}, rom_data[i]};
            prod[i]    = act_ext * wgt_ext[i];
            sum[i]     = acc_q[i] + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
            acc_d[i]   = acc_q[i];
            out_d[i]   = out_q[i];

            // The sum only reaches state on an accept, so unaccepted (possibly
            // unknown) act_in/rom_data never leak into the accumulators.
            if (accept) begin
                acc_d[i] = sum[i];
            end
            if (handshake) begin
                acc_d[i] = '0;
            end
            if (last_accept) begin
                out_d[i] = convert(sum[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            // NOTE: the accumulator and output arrays are reset because a reset
            // mid-pixel must discard partial sums; this is state, not storage.
            for (int i = 0; i < NUM; i++) begin
                acc_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            for (int i = 0; i < NUM; i++) begin
                acc_q[i] <= acc_d[i];
                out_q[i] <= out_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fire5_squeeze_mac.sv
// Directed testbench for fire5_squeeze_mac. A behavioural weight ROM feeds
// rom_data; expected outputs come from hand constants and a small
// integer model of the per-lane sum/rescale/ReLU/saturate.
module tb_fire5_squeeze_mac;

    localparam int WIDTH = 16;
    localparam int ADDR  = 8;
    localparam int NUM   = 32;
    localparam int FRAC  = 8;
    localparam int ACC_W = 40;
    localparam int NCH   = 2 ** ADDR;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] act_in;
    logic             act_valid;
    logic             act_ready;
    logic [ADDR-1:0]  rom_addr;
    logic [WIDTH-1:0] rom_data [0:NUM-1];
    logic [WIDTH-1:0] out_data [0:NUM-1];
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    logic [WIDTH-1:0] wmem    [0:NCH-1][0:NUM-1];
    logic [WIDTH-1:0] acts    [0:NCH-1];
    logic [WIDTH-1:0] exp_out [0:NUM-1];
    logic [WIDTH-1:0] act3    [0:2][0:NCH-1];
    logic [WIDTH-1:0] exp3    [0:2][0:NUM-1];

    int n_total = 0;
    int n_bad   = 0;

    fire5_squeeze_mac #(
        .WIDTH(WIDTH), .ADDR(ADDR), .NUM(NUM), .FRAC(FRAC), .ACC_W(ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .act_in    (act_in),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            rom_data[i] = wmem[rom_addr][i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: exact integer sum, arithmetic shift, ReLU, saturate.
    task automatic compute_expected();
        for (int l = 0; l < NUM; l++) begin
            longint sum = 0;
            longint s;
            for (int c = 0; c < NCH; c++) begin
                sum += longint'($signed(acts[c])) * longint'($signed(wmem[c][l]));
            end
            s = sum >>> FRAC;
            if (s < 0)          exp_out[l] = '0;
            else if (s > 32767) exp_out[l] = 16'h7FFF;
            else                exp_out[l] = s[WIDTH-1:0];
        end
    endtask

    task automatic set_random_weights();
        for (int c = 0; c < NCH; c++) begin
            for (int l = 0; l < NUM; l++) begin
                if (l < 28) wmem[c][l] = 16'($urandom_range(127)) - 16'd64;
                else        wmem[c][l] = 16'($urandom);
            end
        end
    endtask

    task automatic set_random_acts();
        for (int c = 0; c < NCH; c++) begin
            acts[c] = 16'($urandom_range(511)) - 16'd256;
        end
    endtask

    // Feed channels 0..n_acc-1 from acts[], with random idle gaps. Called and
    // returns at a negedge; on return after a full pixel, the last accept
    // happened at the immediately preceding posedge.
    task automatic feed_pixel(input int gap_pct, input int n_acc);
        for (int ch = 0; ch < n_acc; ch++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                act_valid = 1'b0;
                act_in    = 16'($urandom);
                @(negedge clk);
            end
            act_valid = 1'b1;
            act_in    = acts[ch];
            check("rom_addr_at_accept", 32'(rom_addr), 32'(ch));
            check("act_ready_at_accept", 32'(act_ready), 32'd1);
            if (ch == NCH - 1) begin
                check("out_valid_before_last", 32'(out_valid), 32'd0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        act_valid = 1'b0;
        act_in    = 16'($urandom);
    endtask

    task automatic check_outputs(input string tag);
        for (int l = 0; l < NUM; l++) begin
            check($sformatf("%s_lane%0d", tag, l), 32'(out_data[l]), 32'(exp_out[l]));
        end
    endtask

    task automatic do_handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_out_valid_drop", 32'(out_valid), 32'd0);
        check("hs_act_ready_back", 32'(act_ready), 32'd1);
        check("hs_busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pin, chn, pout, last_cyc, cyc;

        rst_n     = 1'b0;
        act_valid = 1'b0;
        act_in    = '0;
        out_ready = 1'b0;

        // Directed weights: lane0 = +1 LSB, lane1 = -1, lane2 = 0x7FFF.
        set_random_weights();
        for (int c = 0; c < NCH; c++) begin
            wmem[c][0] = 16'h0001;
            wmem[c][1] = 16'hFFFF;
            wmem[c][2] = 16'h7FFF;
        end

        @(negedge clk);
        @(negedge clk);
        check("rst_act_ready", 32'(act_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_out_data0", 32'(out_data[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("act_ready_after_release", 32'(act_ready), 32'd1);

        // Pixel 1: all activations 1.0 -> lane0 = 1.0, lane1 ReLU'd to 0.
        for (int c = 0; c < NCH; c++) acts[c] = 16'h0100;
        feed_pixel(0, NCH);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        compute_expected();
        check("lane0_unit", 32'(out_data[0]), 32'h0100);
        check("lane1_relu", 32'(out_data[1]), 32'h0000);
        check_outputs("p1");

        // Hold the result with out_ready low.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_act_ready", 32'(act_ready), 32'd0);
            check("hold_rom_addr", 32'(rom_addr), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_lane0", 32'(out_data[0]), 32'h0100);
            check("hold_lane5", 32'(out_data[5]), 32'(exp_out[5]));
        end
        do_handshake();
        check("retain_lane0", 32'(out_data[0]), 32'h0100);

        // Pixel 2: all-zero activations; any leftover accumulation would show.
        for (int c = 0; c < NCH; c++) acts[c] = 16'h0000;
        feed_pixel(0, NCH);
        compute_expected();
        check("zero_pixel_lane0", 32'(out_data[0]), 32'h0000);
        check_outputs("p2");
        do_handshake();

        // Pixel 3: max positive activations -> lane2 saturates.
        for (int c = 0; c < NCH; c++) acts[c] = 16'h7FFF;
        feed_pixel(0, NCH);
        compute_expected();
        check("lane2_sat", 32'(out_data[2]), 32'h7FFF);
        check_outputs("p3");
        do_handshake();

        // Pixel 4: random weights/activations with ~50% valid gaps.
        set_random_weights();
        set_random_acts();
        feed_pixel(50, NCH);
        check("rand_latency", 32'(out_valid), 32'd1);
        compute_expected();
        check_outputs("p4");
        do_handshake();

        // Abort a pixel after 100 accepts, then run a clean full pixel.
        set_random_acts();
        feed_pixel(20, 100);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_act_ready", 32'(act_ready), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rom_addr", 32'(rom_addr), 32'd0);
        check("abort_out_data3", 32'(out_data[3]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_random_acts();
        feed_pixel(25, NCH);
        compute_expected();
        check_outputs("p5");
        do_handshake();

        // Streaming: act_valid and out_ready held high for 3 pixels.
        for (int p = 0; p < 3; p++) begin
            set_random_acts();
            compute_expected();
            for (int c = 0; c < NCH; c++) act3[p][c] = acts[c];
            for (int l = 0; l < NUM; l++) exp3[p][l] = exp_out[l];
        end
        out_ready = 1'b1;
        pin = 0; chn = 0; pout = 0; last_cyc = 0;
        for (cyc = 0; cyc < 3 * (NCH + 1) + 20 && pout < 3; cyc++) begin
            if (out_valid) begin
                for (int l = 0; l < NUM; l++) begin
                    check($sformatf("stream%0d_lane%0d", pout, l),
                          32'(out_data[l]), 32'(exp3[pout][l]));
                end
                if (pout > 0) begin
                    check("stream_period", 32'(cyc - last_cyc), 32'(NCH + 1));
                end
                last_cyc = cyc;
                pout++;
            end
            if (pin < 3) begin
                act_valid = 1'b1;
                act_in    = act3[pin][chn];
                if (act_ready) begin
                    if (chn == NCH - 1) begin
                        chn = 0;
                        pin++;
                    end else begin
                        chn++;
                    end
                end
            end else begin
                act_valid = 1'b0;
            end
            @(negedge clk);
        end
        act_valid = 1'b0;
        out_ready = 1'b0;
        check("stream_pixel_count", 32'(pout), 32'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fire5_squeeze_mac.md
Name: fire5_squeeze_mac

Overview:
- 1x1 convolution engine for the fire5 squeeze layer. Sits directly downstream of the fire5 squeeze weight ROM and drives that ROM's address.
- Consumes one input activation per input channel per pixel. For each activation it multiplies by the NUM weights returned by the ROM at the current address and accumulates into NUM lanes.
- After the last input channel, it emits NUM rescaled, ReLU'd, saturated outputs for the pixel over a valid/ready handshake.

Parameters:
- WIDTH, 16: activation, weight and output word width (signed two's complement fixed point).
- ADDR, 8: ROM address width; number of input channels per pixel is 2**ADDR.
- NUM, 32: output channels (parallel MAC lanes).
- FRAC, 8: fractional bits of activations and weights; product is rescaled by >>> FRAC.
- ACC_W, 40: accumulator width (2*WIDTH+ADDR), guaranteed overflow-free.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- act_in, input, WIDTH: signed input activation for the current channel.
- act_valid, input, 1: act_in valid.
- act_ready, output, 1: engine accepts act_in this cycle.
- rom_addr, output, ADDR: channel address to the weight ROM (ROM read is combinational, same cycle).
- rom_data, input, WIDTH x NUM (unpacked array [0:NUM-1]): signed weights for rom_addr, one per output lane.
- out_data, output, WIDTH x NUM (unpacked array [0:NUM-1]): per-lane result for the completed pixel.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: downstream accepts out_data.
- busy, output, 1: high while a pixel is partially accumulated or its result is pending.

Behaviour:
- Reset (async assert, sync release): state ACC, channel counter 0, all accumulators 0, out_data all 0, out_valid 0, busy 0, rom_addr 0. act_ready goes high on the first clock after release.
- States:
  - ACC: act_ready=1, out_valid=0.
  - OUT: act_ready=0, out_valid=1.
- rom_addr is the channel counter register, always driven combinationally from it.
- Accept in ACC: on act_valid && act_ready, for every lane i:
  - acc[i] <= acc[i] + sext(act_in) * sext(rom_data[i]) (full 2*WIDTH signed product, sign-extended to ACC_W).
  - Counter increments.
- Cycles with act_valid=0 change nothing; gaps are allowed anywhere.
- Last channel (accept while counter == 2**ADDR-1):
  - Counter wraps to 0 and the state goes to OUT next cycle.
  - out_data[i] is registered the same edge from the final sum (current acc[i] plus this cycle's product).
  - Latency: out_valid rises the cycle after the last accept.
- Output conversion per lane, in order:
  1. s = final_sum >>> FRAC (arithmetic shift, truncation toward -inf).
  2. If s < 0, result = 0 (ReLU).
  3. Else if s > 2**(WIDTH-1)-1, result = 2**(WIDTH-1)-1 (saturate).
  4. Else result = s[WIDTH-1:0].
- OUT state:
  - out_data and out_valid hold stable until out_valid && out_ready.
  - On that handshake: accumulators clear to 0 and the state returns to ACC next cycle. out_data retains its last value; out_valid drops.
  - No activation is accepted in the handshake cycle. Per-pixel minimum period is 2**ADDR+1 cycles.
- busy = (counter != 0) || state == OUT.
- Reset mid-pixel or mid-OUT discards all partial sums and the pending result. The next pixel starts at channel 0.
- act_in/rom_data values are don't-care when not accepted; X on them must not propagate into state.

Test Plan:
- Lane 0 weights all 0x0001, act_in=0x0100 for all 256 channels -> out_data[0]=0x0100; out_valid rises exactly 1 cycle after the 256th accept.
- Lane 1 weights all 0xFFFF (-1), act_in=0x0100 -> out_data[1]=0x0000 (ReLU). Lane 2 weights 0x7FFF, act_in=0x7FFF -> out_data[2]=0x7FFF (saturation).
- Random act_valid gaps (~50% duty), random weights/activations -> out_data bit-exact vs reference model; rom_addr equals accepted-channel index at each accept.
- Hold out_ready=0 for 10 cycles in OUT -> out_data stable, out_valid=1, act_ready=0, rom_addr=0; release -> act_ready=1 next cycle, accumulators cleared (a pixel of zeros yields all-zero outputs).
- Assert rst_n=0 after 100 accepts -> all outputs at reset values immediately. A full new pixel afterward matches the model with no residue from the aborted pixel.
- act_valid and out_ready tied high for 3 pixels -> out_valid pulses every 257 cycles, each result correct.
